// File: rtl/surf_event_pkg.sv
// surf_event_pkg
//   Shared types and defaults for the SURF event merge path.
//   arb_state_t : arbiter FSM state encoding
//   IDX_WIDTH   : width of a SURF source index (fixed at 3 bits)
package surf_event_pkg;

    localparam int NSURF_DEFAULT   = 7;
    localparam int MAX_LEN_DEFAULT = 16384;
    localparam int IDX_WIDTH       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/surf_event_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches req starting at
//   (last_grant + 1) mod NSURF upward with wrap; the first set bit wins.
//   Ports:
//     req        in  NSURF      request vector
//     last_grant in  IDX_WIDTH  index granted most recently
//     grant      out IDX_WIDTH  selected index (0 when no request)
//     any_req    out 1          at least one request present
module rr_pick
    import surf_event_pkg::*;
#(
    parameter int NSURF = NSURF_DEFAULT
) (
    input  logic [NSURF-1:0]     req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [IDX_WIDTH-1:0] grant,
    output logic                 any_req
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NSURF; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NSURF) begin
                idx = idx - NSURF;
            end
            if (!found && req[idx]) begin
                grant = IDX_WIDTH'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/surf_event_arbiter.sv
// surf_event_arbiter
//   Packet-atomic round-robin merge of NSURF SURF byte streams into one
//   AXI4-Stream, tagging each beat with its source index. Packets longer
//   than MAX_LEN are cut with a forced tlast and their tail is flushed.
//
//   state | meaning
//   IDLE  | arbitration bubble; pick next requester round-robin
//   PASS  | combinational passthrough of granted source
//   FLUSH | drain truncated packet tail, nothing forwarded
//
//   Ports:
//     sysclk_i, sysclk_rstn_i   clock, async active-low reset
//     enable_i                  per-source arbitration enable
//     s_t*                      per-source input streams (byte k at [8k+7:8k])
//     m_t*                      merged output stream, m_tuser = source index
//     trunc_err_o, trunc_clr_i  sticky per-source truncation flags and clear
//     pkt_count_o               forwarded packet count, wraps
//     busy_o                    high while a packet is owned (PASS/FLUSH)
module surf_event_arbiter
    import surf_event_pkg::*;
#(
    parameter int NSURF     = NSURF_DEFAULT,
    parameter int MAX_LEN   = MAX_LEN_DEFAULT,
    parameter int LEN_WIDTH = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sysclk_i,
    input  logic                 sysclk_rstn_i,
    input  logic [NSURF-1:0]     enable_i,
    input  logic [8*NSURF-1:0]   s_tdata,
    input  logic [NSURF-1:0]     s_tvalid,
    output logic [NSURF-1:0]     s_tready,
    input  logic [NSURF-1:0]     s_tlast,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [IDX_WIDTH-1:0] m_tuser,
    output logic [NSURF-1:0]     trunc_err_o,
    input  logic                 trunc_clr_i,
    output logic [CNT_WIDTH-1:0] pkt_count_o,
    output logic                 busy_o
);

    localparam logic [LEN_WIDTH-1:0] LEN_LAST = LEN_WIDTH'(MAX_LEN - 1);

    arb_state_t           state;
    logic [IDX_WIDTH-1:0] grant;
    logic [IDX_WIDTH-1:0] last_grant;
    logic [LEN_WIDTH-1:0] byte_cnt;
    logic [IDX_WIDTH-1:0] pick;
    logic                 any_req;
    logic                 at_max;
    logic                 m_hs;
    logic                 src_last;
    logic [NSURF-1:0]     trunc_set;

    rr_pick #(.NSURF(NSURF)) u_rr_pick (
        .req        (s_tvalid & enable_i),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    assign at_max   = (byte_cnt == LEN_LAST);
    assign src_last = s_tlast[grant];
    assign m_hs     = (state == PASS) && s_tvalid[grant] && m_tready;
    // Real tlast on the boundary beat takes precedence, so no error then.
    assign trunc_set = (m_hs && at_max && !src_last) ? (NSURF'(1) << grant) : '0;

    always_comb begin
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = '0;
        case (state)
            PASS: begin
                s_tready[grant] = m_tready;
                m_tdata         = s_tdata[{grant, 3'b000} +: 8];
                m_tvalid        = s_tvalid[grant];
                m_tlast         = src_last | at_max;
                m_tuser         = grant;
            end
            FLUSH: begin
                s_tready[grant] = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= IDX_WIDTH'(NSURF - 1);
            byte_cnt    <= '0;
            trunc_err_o <= '0;
            pkt_count_o <= '0;
        end else begin
            trunc_err_o <= (trunc_clr_i ? '0 : trunc_err_o) | trunc_set;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= pick;
                        byte_cnt <= '0;
                        state    <= PASS;
                    end
                end
                PASS: begin
                    if (m_hs) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (src_last || at_max) begin
                            last_grant  <= grant;
                            pkt_count_o <= pkt_count_o + 1'b1;
                            state       <= src_last ? IDLE : FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (s_tvalid[grant] && src_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
